// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 VGA timing generator with a clk-to-pixel tick divider.
// Counters, syncs and video_on are all registered and load together on each tick.
module vga_sync_gen #(
    parameter int HD       = 640,
    parameter int HF       = 16,
    parameter int HR       = 96,
    parameter int HB       = 48,
    parameter int VD       = 480,
    parameter int VF       = 10,
    parameter int VR       = 2,
    parameter int VB       = 33,
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DLAST = DW'(TICK_DIV - 1);
    localparam logic [9:0] HMAX = 10'(HD + HF + HR + HB - 1);
    localparam logic [9:0] VMAX = 10'(VD + VF + VR + VB - 1);
    localparam logic [9:0] HS0  = 10'(HD + HF);
    localparam logic [9:0] HS1  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] VS0  = 10'(VD + VF);
    localparam logic [9:0] VS1  = 10'(VD + VF + VR - 1);
    localparam logic [9:0] HDL  = 10'(HD);
    localparam logic [9:0] VDL  = 10'(VD);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          run_q, run_d, p_tick_q, p_tick_d, video_on_q, video_on_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, frame_end_q, frame_end_d;
    logic          tick, adv;

    // The first tick after reset only presents (0,0); later ticks advance.
    always_comb begin
        tick        = div_q == DLAST;
        adv         = tick & run_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        run_d       = run_q | tick;
        pix_x_d     = !adv ? pix_x_q : (pix_x_q == HMAX ? '0 : pix_x_q + 10'd1);
        pix_y_d     = !(adv && pix_x_q == HMAX) ? pix_y_q : (pix_y_q == VMAX ? '0 : pix_y_q + 10'd1);
        p_tick_d    = tick;
        frame_end_d = adv && pix_x_q == HMAX && pix_y_q == VMAX;
        hsync_d     = tick ? !(pix_x_d >= HS0 && pix_x_d <= HS1) : hsync_q;
        vsync_d     = tick ? !(pix_y_d >= VS0 && pix_y_d <= VS1) : vsync_q;
        video_on_d  = tick ? (pix_x_d < HDL && pix_y_d < VDL) : video_on_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q       <= '0;
            run_q       <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            p_tick_q    <= 1'b0;
            video_on_q  <= 1'b0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            run_q       <= run_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            p_tick_q    <= p_tick_d;
            video_on_q  <= video_on_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign p_tick    = p_tick_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign video_on  = video_on_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign frame_end = frame_end_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: three instances (default, TICK_DIV=1, small raster) checked
// against a closed-form model of tick index -> raster position.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    longint k = 0;
    int total = 0;
    int bad = 0;
    bit sb_on = 1'b0;

    logic p0, vo0, hs0, vs0, fe0, p1, vo1, hs1, vs1, fe1, p2, vo2, hs2, vs2, fe2;
    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [24:0] o0, o1, o2;
    localparam logic [24:0] RST_V = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    vga_sync_gen dut0 (.clk(clk), .reset(reset), .p_tick(p0), .pix_x(x0), .pix_y(y0),
        .video_on(vo0), .hsync(hs0), .vsync(vs0), .frame_end(fe0));
    vga_sync_gen #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(reset), .p_tick(p1), .pix_x(x1),
        .pix_y(y1), .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_end(fe1));
    vga_sync_gen #(.HD(16), .HF(2), .HR(3), .HB(4), .VD(6), .VF(2), .VR(1), .VB(3), .TICK_DIV(3))
        dut2 (.clk(clk), .reset(reset), .p_tick(p2), .pix_x(x2), .pix_y(y2),
        .video_on(vo2), .hsync(hs2), .vsync(vs2), .frame_end(fe2));

    assign o0 = {p0, x0, y0, vo0, hs0, vs0, fe0};
    assign o1 = {p1, x1, y1, vo1, hs1, vs1, fe1};
    assign o2 = {p2, x2, y2, vo2, hs2, vs2, fe2};

    // k = clk edges seen since reset release; tick number t = k/d, pixel p = t-1.
    function automatic logic [24:0] model(longint kk, int d, int hd, int hf, int hr, int hb,
                                          int vd, int vf, int vr, int vb);
        longint t, p, h, v, px, py;
        logic pt, fe;
        t = kk / d;
        if (t == 0) return RST_V;
        h = hd + hf + hr + hb;
        v = vd + vf + vr + vb;
        p = t - 1;
        px = p % h;
        py = (p / h) % v;
        pt = (kk % d) == 0;
        fe = pt && p > 0 && (p % (h * v)) == 0;
        return {pt, 10'(px), 10'(py), px < hd && py < vd, !(px >= hd + hf && px < hd + hf + hr),
                !(py >= vd + vf && py < vd + vf + vr), fe};
    endfunction

    always @(posedge clk or posedge reset) k <= reset ? 0 : k + 1;

    always @(posedge clk) begin
        logic [24:0] e0, e1, e2;
        #2;
        if (sb_on) begin
            e0 = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
            e1 = model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33);
            e2 = model(k, 3, 16, 2, 3, 4, 6, 2, 1, 3);
            total += 3;
            if (o0 !== e0) begin bad++; $display("FAIL sb_dut0 k=%0d got=%h exp=%h", k, o0, e0); end
            if (o1 !== e1) begin bad++; $display("FAIL sb_dut1 k=%0d got=%h exp=%h", k, o1, e1); end
            if (o2 !== e2) begin bad++; $display("FAIL sb_dut2 k=%0d got=%h exp=%h", k, o2, e2); end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (o0 !== RST_V) begin bad++; $display("FAIL reset_dut0 got=%h exp=%h", o0, RST_V); end
        if (o1 !== RST_V) begin bad++; $display("FAIL reset_dut1 got=%h exp=%h", o1, RST_V); end
        if (o2 !== RST_V) begin bad++; $display("FAIL reset_dut2 got=%h exp=%h", o2, RST_V); end
        sb_on = 1'b1;
    endtask

    task automatic test_first_tick();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (p0 !== (i == 4)) begin bad++; $display("FAIL first_tick edge=%0d got=%b exp=%b", i, p0, i == 4); end
            if (i == 1) begin
                total++;
                if (p1 !== 1'b1) begin bad++; $display("FAIL div1_tick got=%b exp=1", p1); end
            end
        end
        total++;
        if ({x0, y0, vo0, hs0, vs0} !== {10'd0, 10'd0, 3'b111})
            begin bad++; $display("FAIL first_tick_state got=%h exp=%h", {x0, y0, vo0, hs0, vs0}, {10'd0, 10'd0, 3'b111}); end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int fall_x = -1;
        for (int i = 5; i <= 3204; i++) begin
            @(posedge clk);
            #1;
            if (p0 && !hs0) hs_low++;
            if (p0 && y0 == 0 && !vo0 && fall_x < 0) fall_x = int'(x0);
            if (i == 801) begin
                total++;
                if ({x1, y1} !== {10'd0, 10'd1}) begin bad++; $display("FAIL div1_line got=%h exp=%h", {x1, y1}, {10'd0, 10'd1}); end
            end
        end
        total += 3;
        if (hs_low !== 96) begin bad++; $display("FAIL hsync_width got=%0d exp=96", hs_low); end
        if (fall_x !== 640) begin bad++; $display("FAIL video_fall got=%0d exp=640", fall_x); end
        if ({x0, y0, vo0} !== {10'd0, 10'd1, 1'b1}) begin bad++; $display("FAIL line_wrap got=%h exp=%h", {x0, y0, vo0}, {10'd0, 10'd1, 1'b1}); end
    endtask

    task automatic test_frame();
        int fe_n = 0, vsl = 0, von = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (1803) begin
            @(posedge clk);
            #1;
            if (p2 && !vs2) vsl++;
            if (p2 && vo2) von++;
            if (fe2) begin
                fe_n++;
                total++;
                if ({p2, x2, y2} !== {1'b1, 20'd0}) begin bad++; $display("FAIL frame_end_pos got=%h exp=%h", {p2, x2, y2}, {1'b1, 20'd0}); end
            end
        end
        total += 3;
        if (fe_n !== 2) begin bad++; $display("FAIL frame_end_count got=%0d exp=2", fe_n); end
        if (vsl !== 50) begin bad++; $display("FAIL vsync_ticks got=%0d exp=50", vsl); end
        if (von !== 193) begin bad++; $display("FAIL video_ticks got=%0d exp=193", von); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6000 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = x0 == 10'd300 && y0 == 10'd1;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL mid_wait got=timeout exp=x300_y1"); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total += 2;
        if (o0 !== RST_V) begin bad++; $display("FAIL mid_reset_dut0 got=%h exp=%h", o0, RST_V); end
        if (o1 !== RST_V) begin bad++; $display("FAIL mid_reset_dut1 got=%h exp=%h", o1, RST_V); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (p0 !== (i == 4)) begin bad++; $display("FAIL restart_tick edge=%0d got=%b exp=%b", i, p0, i == 4); end
        end
        total++;
        if ({x0, y0, vo0} !== {10'd0, 10'd0, 1'b1}) begin bad++; $display("FAIL restart_pos got=%h exp=%h", {x0, y0, vo0}, {10'd0, 10'd0, 1'b1}); end
    endtask

    task automatic test_random_resets();
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(1, 2500)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(0, 3));
            reset = 1'b1;
            #1;
            total++;
            if (o2 !== RST_V) begin bad++; $display("FAIL rand_reset n=%0d got=%h exp=%h", n, o2, RST_V); end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        repeat (200) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_line();
        test_frame();
        test_reset_mid();
        test_random_resets();
        @(negedge clk);
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
